// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request, fetch and byte-bus signal bundle for mem_ctrl
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  // global control
  logic              rdy;
  logic              rollback;
  // LSB request / response
  logic              mc_en;
  logic              mc_wr;
  logic [ADDR_W-1:0] mc_addr;
  logic [2:0]        mc_len;
  logic [31:0]       mc_w_data;
  logic              mc_done;
  logic [31:0]       mc_r_data;
  // instruction fetch request / response
  logic              if_en;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;
  // byte-wide RAM / IO bus
  logic              io_buffer_full;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  // requester, fetch unit and RAM side
  modport master (
    output rdy, rollback,
    output mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
    input  mc_done, mc_r_data,
    output if_en, if_addr,
    input  if_done, if_data,
    output io_buffer_full, mem_din,
    input  mem_dout, mem_a, mem_wr
  );

  // controller side
  modport slave (
    input  rdy, rollback,
    input  mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
    output mc_done, mc_r_data,
    input  if_en, if_addr,
    output if_done, if_data,
    input  io_buffer_full, mem_din,
    output mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - LSB/fetch arbiter serialising requests onto a byte-wide RAM/IO bus
module mem_ctrl #(
  parameter int              ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_MASK = ADDR_W'(32'h0003_0000)
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [2:0]        r_cnt;
  logic [2:0]        r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data;
  logic [31:0]       r_mc_rdata;
  logic [31:0]       r_if_data;
  logic              r_mc_done;
  logic              r_if_done;

  logic              w_accept;
  logic [2:0]        w_req_len;
  logic              w_is_io;
  logic              w_stall;
  logic              w_last_wr;
  logic              w_last_rd;
  logic [31:0]       w_cap_data;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [7:0]        w_store_byte;
  logic [ADDR_W-1:0] w_mem_a;
  logic [7:0]        w_mem_dout;
  logic              w_mem_wr;

  // a done cycle never accepts: the requester is still holding its enable
  assign w_accept = (r_state == S_IDLE) && !r_mc_done && !r_if_done &&
                    !bus.rollback && (bus.mc_en || bus.if_en);

  // current byte address; wraps naturally at 2^ADDR_W
  assign w_cur_addr = r_addr + {{(ADDR_W-3){1'b0}}, r_cnt};

  assign w_is_io   = ((r_addr & IO_MASK) == IO_MASK);
  assign w_stall   = w_is_io && bus.io_buffer_full;
  assign w_last_wr = (r_cnt == (r_len - 3'd1));
  // a read spends one extra cycle after its last address to capture the byte
  assign w_last_rd = (r_cnt == r_len);

  // anything other than 1 or 2 bytes is a full word
  always_comb begin
    case (bus.mc_len)
      3'd1:    w_req_len = 3'd1;
      3'd2:    w_req_len = 3'd2;
      default: w_req_len = 3'd4;
    endcase
  end

  // merge the byte returned for the previous cycle's address into the word
  always_comb begin
    w_cap_data = r_data;
    case (r_cnt)
      3'd1:    w_cap_data[7:0]   = bus.mem_din;
      3'd2:    w_cap_data[15:8]  = bus.mem_din;
      3'd3:    w_cap_data[23:16] = bus.mem_din;
      3'd4:    w_cap_data[31:24] = bus.mem_din;
      default: w_cap_data = r_data;
    endcase
  end

  // little-endian byte lane of the latched store data
  always_comb begin
    case (r_cnt[1:0])
      2'd0:    w_store_byte = r_wdata[7:0];
      2'd1:    w_store_byte = r_wdata[15:8];
      2'd2:    w_store_byte = r_wdata[23:16];
      default: w_store_byte = r_wdata[31:24];
    endcase
  end

  // state register; rdy low freezes the sequence
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (bus.rdy) begin
      r_state <= w_next_state;
    end
  end

  // next-state: LSB wins arbitration, reads abort on rollback, stores always finish
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.mc_en) begin
            w_next_state = bus.mc_wr ? S_STORE : S_LOAD;
          end else begin
            w_next_state = S_FETCH;
          end
        end
      end
      S_LOAD, S_FETCH: begin
        if (bus.rollback || w_last_rd) begin
          w_next_state = S_IDLE;
        end
      end
      S_STORE: begin
        if (!w_stall && w_last_wr) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // bus outputs; writes only when running and the IO buffer has room
  always_comb begin
    w_mem_a    = '0;
    w_mem_dout = 8'h00;
    w_mem_wr   = 1'b0;
    case (r_state)
      S_LOAD, S_FETCH: begin
        w_mem_a = w_cur_addr;
      end
      S_STORE: begin
        w_mem_a    = w_cur_addr;
        w_mem_dout = w_store_byte;
        w_mem_wr   = bus.rdy && !w_stall;
      end
      default: begin
        w_mem_a    = '0;
        w_mem_dout = 8'h00;
        w_mem_wr   = 1'b0;
      end
    endcase
  end

  // request latch, byte counter, read assembly and done pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 3'd0;
      r_len      <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_data     <= 32'h0;
      r_mc_rdata <= 32'h0;
      r_if_data  <= 32'h0;
      r_mc_done  <= 1'b0;
      r_if_done  <= 1'b0;
    end else if (bus.rdy) begin
      r_mc_done <= 1'b0;
      r_if_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= 3'd0;
            r_data  <= 32'h0;
            r_wdata <= bus.mc_w_data;
            if (bus.mc_en) begin
              r_addr <= bus.mc_addr;
              r_len  <= w_req_len;
            end else begin
              r_addr <= bus.if_addr;
              r_len  <= 3'd4;
            end
          end
        end
        S_LOAD, S_FETCH: begin
          if (bus.rollback) begin
            r_cnt  <= 3'd0;
            r_data <= 32'h0;
          end else if (w_last_rd) begin
            r_cnt  <= 3'd0;
            r_data <= w_cap_data;
            if (r_state == S_LOAD) begin
              r_mc_done  <= 1'b1;
              r_mc_rdata <= w_cap_data;
            end else begin
              r_if_done  <= 1'b1;
              r_if_data  <= w_cap_data;
            end
          end else begin
            r_data <= w_cap_data;
            r_cnt  <= r_cnt + 3'd1;
          end
        end
        S_STORE: begin
          if (!w_stall) begin
            if (w_last_wr) begin
              r_cnt     <= 3'd0;
              r_mc_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        default: begin
          r_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign bus.mem_a     = w_mem_a;
  assign bus.mem_dout  = w_mem_dout;
  assign bus.mem_wr    = w_mem_wr;
  assign bus.mc_done   = r_mc_done;
  assign bus.mc_r_data = r_mc_rdata;
  assign bus.if_done   = r_if_done;
  assign bus.if_data   = r_if_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with RAM model and response scoreboard
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .IO_MASK(32'h0003_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          cyc;
    int          nwr;
  } vec_t;

  exp_t mc_q[$];
  exp_t if_q[$];
  exp_t e_m;
  exp_t e_i;

  logic [7:0] ram [int unsigned];
  logic [7:0] rd_b;

  int wr_cnt      = 0;
  int mc_done_cnt = 0;
  bit prev_mc     = 1'b0;
  bit prev_if     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // RAM returns the byte for the address presented the previous cycle; shares rdy
  always @(posedge clk) begin
    if (bus.rdy === 1'b1) begin
      rd_b = ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
      if (bus.mem_wr === 1'b1) ram[bus.mem_a] = bus.mem_dout;
      bus.mem_din <= rd_b;
    end
  end

  // scoreboard: every done pulse pops and checks one expected response
  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) wr_cnt++;
    if (bus.mc_done === 1'b1) begin
      mc_done_cnt++;
      chk("mc_done single cycle", {31'b0, prev_mc}, 32'd0);
      chk("mc_done expected", {31'b0, (mc_q.size() > 0)}, 32'd1);
      if (mc_q.size() > 0) begin
        e_m = mc_q.pop_front();
        if (e_m.chk) chk("mc_r_data", bus.mc_r_data, e_m.data);
      end
    end
    if (bus.if_done === 1'b1) begin
      chk("if_done single cycle", {31'b0, prev_if}, 32'd0);
      chk("if_done expected", {31'b0, (if_q.size() > 0)}, 32'd1);
      if (if_q.size() > 0) begin
        e_i = if_q.pop_front();
        if (e_i.chk) chk("if_data", bus.if_data, e_i.data);
      end
    end
    prev_mc = (bus.mc_done === 1'b1);
    prev_if = (bus.if_done === 1'b1);
  end

  // counts negedges until done, then drops the enable one cycle later
  task automatic wait_done(input bit is_if, output int n);
    n = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if ((is_if ? bus.if_done : bus.mc_done) === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("done timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (is_if) bus.if_en = 1'b0;
    else bus.mc_en = 1'b0;
  endtask

  task automatic drive_mc(input bit wr, input logic [31:0] addr, input logic [2:0] len,
                          input logic [31:0] wdata);
    bus.mc_wr     = wr;
    bus.mc_addr   = addr;
    bus.mc_len    = len;
    bus.mc_w_data = wdata;
    bus.mc_en     = 1'b1;
  endtask

  vec_t vecs [10];
  int   n;
  int   n_mc;
  int   n_if;
  int   done_snap;

  initial begin
    bus.rdy = 1'b1; bus.rollback = 1'b0; bus.mc_en = 1'b0; bus.mc_wr = 1'b0;
    bus.mc_addr = 32'h0; bus.mc_len = 3'd0; bus.mc_w_data = 32'h0;
    bus.if_en = 1'b0; bus.if_addr = 32'h0; bus.io_buffer_full = 1'b0;
    ram[32'h1000] = 8'h11; ram[32'h1001] = 8'h22;
    ram[32'h1002] = 8'h33; ram[32'h1003] = 8'h44;

    vecs[0] = '{1'b1, 32'h0000_2002, 3'd2, 32'hDEAD_BEEF, 32'h0,         4, 2};
    vecs[1] = '{1'b0, 32'h0000_2002, 3'd2, 32'h0,         32'h0000_BEEF, 5, 0};
    vecs[2] = '{1'b1, 32'h0000_3000, 3'd4, 32'hA1B2_C3D4, 32'h0,         6, 4};
    vecs[3] = '{1'b0, 32'h0000_3000, 3'd4, 32'h0,         32'hA1B2_C3D4, 7, 0};
    vecs[4] = '{1'b0, 32'h0000_3001, 3'd1, 32'h0,         32'h0000_00C3, 4, 0};
    vecs[5] = '{1'b1, 32'h0000_3004, 3'd3, 32'h5566_7788, 32'h0,         6, 4};
    vecs[6] = '{1'b0, 32'h0000_3004, 3'd0, 32'h0,         32'h5566_7788, 7, 0};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 3'd2, 32'h0000_1234, 32'h0,         4, 2};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0,         32'h0000_1234, 5, 0};
    vecs[9] = '{1'b0, 32'h0000_0000, 3'd1, 32'h0,         32'h0000_0012, 4, 0};

    // reset state
    repeat (2) @(negedge clk);
    chk("reset mc_done", {31'b0, bus.mc_done}, 32'd0);
    chk("reset if_done", {31'b0, bus.if_done}, 32'd0);
    chk("reset mc_r_data", bus.mc_r_data, 32'd0);
    chk("reset if_data", bus.if_data, 32'd0);
    chk("reset mem_a", bus.mem_a, 32'd0);
    chk("reset mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    chk("reset mem_dout", {24'b0, bus.mem_dout}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    // plain fetch
    @(posedge clk); #1;
    wr_cnt = 0;
    if_q.push_back('{chk: 1'b1, data: 32'h4433_2211});
    bus.if_addr = 32'h1000; bus.if_en = 1'b1;
    wait_done(1'b1, n);
    chk("fetch latency", n, 32'd7);
    chk("fetch no write", wr_cnt, 32'd0);

    // table of stores and loads
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      wr_cnt = 0;
      mc_q.push_back('{chk: !vecs[i].wr, data: vecs[i].exp});
      drive_mc(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wdata);
      wait_done(1'b0, n);
      chk($sformatf("vec%0d latency", i), n, vecs[i].cyc);
      chk($sformatf("vec%0d writes", i), wr_cnt, vecs[i].nwr);
    end
    chk("ram 2002", {24'b0, ram[32'h2002]}, 32'hEF);
    chk("ram 2003", {24'b0, ram[32'h2003]}, 32'hBE);
    chk("ram 2004 untouched", {31'b0, ram.exists(32'h2004) != 0}, 32'd0);
    chk("ram 3007", {24'b0, ram[32'h3007]}, 32'h55);
    chk("ram wrap 0", {24'b0, ram[32'h0]}, 32'h12);

    // simultaneous requests: LSB first, fetch after the done cycle
    @(posedge clk); #1;
    mc_q.push_back('{chk: 1'b1, data: 32'h0000_0011});
    if_q.push_back('{chk: 1'b1, data: 32'h4433_2211});
    drive_mc(1'b0, 32'h1000, 3'd1, 32'h0);
    bus.if_addr = 32'h1000; bus.if_en = 1'b1;
    n_mc = 0; n_if = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus.mc_done === 1'b1) n_mc = i;
      if (bus.if_done === 1'b1) n_if = i;
      @(posedge clk); #1;
      if (n_mc == i) bus.mc_en = 1'b0;
      if (n_if == i) begin
        bus.if_en = 1'b0;
        break;
      end
    end
    bus.mc_en = 1'b0; bus.if_en = 1'b0;
    chk("arb lsb done", n_mc, 32'd4);
    chk("arb fetch done", n_if, 32'd11);

    // IO store stalled by a full buffer for five cycles
    @(posedge clk); #1;
    wr_cnt = 0;
    mc_q.push_back('{chk: 1'b0, data: 32'h0});
    bus.io_buffer_full = 1'b1;
    drive_mc(1'b1, 32'h0003_0000, 3'd1, 32'h0000_00AB);
    repeat (6) @(posedge clk);
    #1;
    chk("io stall no write", wr_cnt, 32'd0);
    bus.io_buffer_full = 1'b0;
    wait_done(1'b0, n);
    chk("io store latency", n, 32'd2);
    chk("io store writes", wr_cnt, 32'd1);
    chk("io store data", {24'b0, ram[32'h0003_0000]}, 32'hAB);

    // rollback aborts a load on its second byte
    @(posedge clk); #1;
    done_snap = mc_done_cnt;
    drive_mc(1'b0, 32'h3000, 3'd4, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.rollback = 1'b1; bus.mc_en = 1'b0;
    @(posedge clk); #1;
    bus.rollback = 1'b0;
    chk("rollback to idle", 32'(dut.r_state), 32'd0);
    repeat (10) @(negedge clk);
    chk("rollback no done", mc_done_cnt, done_snap);

    // rollback does not stop a store
    @(posedge clk); #1;
    wr_cnt = 0;
    mc_q.push_back('{chk: 1'b0, data: 32'h0});
    drive_mc(1'b1, 32'h4000, 3'd4, 32'h0A0B_0C0D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.rollback = 1'b1;
    @(posedge clk); #1;
    bus.rollback = 1'b0;
    wait_done(1'b0, n);
    chk("rb store latency", n, 32'd3);
    chk("rb store writes", wr_cnt, 32'd4);
    chk("rb store byte0", {24'b0, ram[32'h4000]}, 32'h0D);
    chk("rb store byte3", {24'b0, ram[32'h4003]}, 32'h0A);

    // asynchronous reset in the middle of a store
    @(posedge clk); #1;
    drive_mc(1'b1, 32'h5000, 3'd4, 32'h1122_3344);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset write", {31'b0, bus.mem_wr}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    chk("rst mem_a", bus.mem_a, 32'd0);
    chk("rst mem_dout", {24'b0, bus.mem_dout}, 32'd0);
    chk("rst mc_r_data", bus.mc_r_data, 32'd0);
    chk("rst if_data", bus.if_data, 32'd0);
    bus.mc_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // rdy low for three cycles during a fetch
    @(posedge clk); #1;
    if_q.push_back('{chk: 1'b1, data: 32'h4433_2211});
    bus.if_addr = 32'h1000; bus.if_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("frozen mem_a %0d", i), bus.mem_a, 32'h1001);
      chk($sformatf("frozen cnt %0d", i), 32'(dut.r_cnt), 32'd1);
    end
    @(posedge clk); #1;
    bus.rdy = 1'b1;
    wait_done(1'b1, n);
    chk("rdy fetch latency", n, 32'd5);

    // rdy low forces mem_wr off during a store
    @(posedge clk); #1;
    wr_cnt = 0;
    mc_q.push_back('{chk: 1'b0, data: 32'h0});
    drive_mc(1'b1, 32'h6000, 3'd2, 32'h0000_BBAA);
    @(posedge clk); #1;
    bus.rdy = 1'b0;
    #1;
    chk("rdy low mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    @(posedge clk); #1;
    bus.rdy = 1'b1;
    wait_done(1'b0, n);
    chk("rdy store writes", wr_cnt, 32'd2);
    chk("rdy store byte1", {24'b0, ram[32'h6001]}, 32'hBB);

    repeat (3) @(negedge clk);
    chk("mc queue drained", mc_q.size(), 32'd0);
    chk("if queue drained", if_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder for the LSB memory-request interface and for the instruction-fetch port.
- Arbitrates between the two, then serialises each request onto the byte-wide RAM/IO bus: one byte per cycle, little-endian.
- Returns read data or a store acknowledgement with a one-cycle done pulse.
- Sits between the LSB/fetch unit and the external RAM and IO.

Parameters:
ADDR_W, 32, address width of all address ports
IO_MASK, 32'h0003_0000, address bits that select IO space when all set; IO writes stall on io_buffer_full

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
rdy  in  1  global ready; low freezes the block
rollback  in  1  pipeline flush; aborts in-flight reads
mc_en  in  1  LSB request valid, held until mc_done
mc_wr  in  1  LSB request type, 1 = store
mc_addr  in  ADDR_W  LSB byte address
mc_len  in  3  LSB access size: 1, 2 or 4 bytes
mc_w_data  in  32  store data; low mc_len bytes used
mc_done  out  1  one-cycle LSB completion pulse
mc_r_data  out  32  load data, zero-extended in upper bytes, valid with mc_done
if_en  in  1  fetch request valid, held until if_done
if_addr  in  ADDR_W  fetch word address
if_done  out  1  one-cycle fetch completion pulse
if_data  out  32  fetched word, valid with if_done
io_buffer_full  in  1  IO write buffer full
mem_din  in  8  RAM read byte for the address presented the previous cycle
mem_dout  out  8  write byte
mem_a  out  ADDR_W  byte address
mem_wr  out  1  1 = write this cycle

Behaviour:
Reset:
- All outputs 0, state IDLE, byte counter 0, data shift register 0.

rdy low:
- Every register holds.
- mem_wr is forced to 0 combinationally.

States: IDLE, FETCH, LOAD, STORE.
- The byte counter `cnt` is 3 bits; the request length `len` is latched at accept.

IDLE, accepting a request:
- No request is accepted in any cycle where mc_done or if_done is high. The requester deasserts its enable only one cycle after seeing done.
- mc_en has priority over if_en.
- mc_en && mc_wr -> STORE; mc_en && !mc_wr -> LOAD; if_en only -> FETCH with len = 4.
- On accept, latch address, len and write data; set cnt = 0; drive mem_a = addr, and for STORE drive mem_dout = byte 0.

LOAD / FETCH:
- Cycle k (k = 0 .. len-1): drive mem_a = base + k.
- Cycle k+1: capture mem_din into byte k.
- Total len+1 cycles from accept to the capture of the last byte.
- On the edge after the last capture: pulse done for exactly one cycle with the assembled word, then return to IDLE.
- A read occupies len+2 cycles from the accept edge to the done cycle inclusive.

STORE:
- Each cycle: drive mem_a = base + cnt, mem_dout = byte cnt, mem_wr = 1, then cnt++.
- After byte len-1 is written: pulse mc_done and return to IDLE.
- IO stall: if (addr & IO_MASK) == IO_MASK and io_buffer_full, then mem_wr = 0 and cnt holds until io_buffer_full drops.

Rollback:
- LOAD or FETCH in flight: abort immediately, go to IDLE, no done pulse, mem_wr = 0.
- STORE in flight: continues to completion. Only committed stores are issued.
- Rollback in IDLE blocks accept that cycle.

Address arithmetic:
- base + k wraps modulo 2^ADDR_W.
- mc_len values other than 1, 2 or 4 are treated as 4.

Simultaneous requests:
- mc_en and if_en together: LSB is served; fetch waits, with if_en held, until the next IDLE accept.

Test Plan:
- Write 0x00001000..0x00001003 = 11,22,33,44 into RAM; fetch if_addr = 0x1000 -> if_done one cycle after 6 cycles, if_data = 0x44332211, mem_wr never 1.
- Store mc_addr = 0x2002, len = 2, w_data = 0xDEADBEEF -> mem_wr = 1 for 2 cycles with bytes EF, BE at 0x2002, 0x2003; mc_done pulse; then load len = 2 from 0x2002 -> mc_r_data = 0x0000BEEF.
- mc_en (load, len 1) and if_en raised in the same cycle -> LSB served first; fetch starts 1 cycle after mc_done; no double accept during the done cycle.
- Store len 1 to 0x30000 with io_buffer_full high for 5 cycles -> mem_wr stays 0 for 5 cycles, then one write, then mc_done.
- Load len 4 with rollback asserted on its 2nd byte -> no mc_done, state IDLE next cycle; store with rollback mid-way -> all 4 bytes written and mc_done pulses.
- rst pulled low mid-store, then rdy held low 3 cycles during a fetch -> all outputs 0 immediately on reset; under rdy low mem_a and cnt frozen and mem_wr 0; completion delayed exactly 3 cycles.
